// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
//
// Converts an 8-bit unsigned value into three BCD digits with a sequential
// shift-and-add-3 (double dabble) engine, then time-multiplexes those digits
// onto a single 7-segment driver.
//
// A conversion is started whenever bin differs from the last value captured.
// The running conversion ignores bin; a newer value is picked up on the first
// IDLE cycle after the commit. The display only ever shows the committed
// result, so partial accumulator values never reach the segments.
//
// Handshake: none on the input side. done is a one-cycle pulse on the edge that
// loads bcd; busy is high from the capture edge up to (not including) that edge.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   bin       value to display
//   busy      conversion in progress
//   done      one-cycle pulse when bcd is updated
//   bcd       committed result {hundreds[9:8], tens[7:4], ones[3:0]}
//   seg       active-high segments, seg[6]=a .. seg[0]=g, for the enabled digit
//   digit_en  one-hot digit select: bit0 ones, bit1 tens, bit2 hundreds
//
// The FSM state register is named 'state' for hierarchical observation.
// -----------------------------------------------------------------------------
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [9:0] bcd,
  output logic [6:0] seg,
  output logic [2:0] digit_en
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  last_bin;
  logic [7:0]  shift_reg;
  logic [9:0]  acc;
  logic [2:0]  iter;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]  digit_idx;

  // Add-3 correction applied before each shift. The hundreds field never
  // exceeds 1 before the final shift, so it needs no correction.
  logic [9:0] acc_adj;
  always_comb begin
    acc_adj = acc;
    if (acc[3:0] >= 4'd5) acc_adj[3:0] = acc[3:0] + 4'd3;
    if (acc[7:4] >= 4'd5) acc_adj[7:4] = acc[7:4] + 4'd3;
  end

  // Conversion FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      last_bin  <= '0;
      shift_reg <= '0;
      acc       <= '0;
      iter      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bin != last_bin) begin
            shift_reg <= bin;
            acc       <= '0;
            last_bin  <= bin;
            iter      <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          acc       <= {acc_adj[8:0], shift_reg[7]};
          shift_reg <= {shift_reg[6:0], 1'b0};
          iter      <= iter + 3'd1;
          if (iter == 3'd7) state <= COMMIT;
        end
        COMMIT: begin
          bcd   <= acc;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Refresh timer and digit rotation: ones -> tens -> hundreds -> ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Digit select and segment decode from the committed result only
  logic [3:0] cur_digit;
  logic       blank;
  always_comb begin
    digit_en  = 3'b001;
    cur_digit = bcd[3:0];
    blank     = 1'b0;
    case (digit_idx)
      2'd1: begin
        digit_en  = 3'b010;
        cur_digit = bcd[7:4];
        blank     = BLANK_LZ && (bcd[9:8] == 2'd0) && (bcd[7:4] == 4'd0);
      end
      2'd2: begin
        digit_en  = 3'b100;
        cur_digit = {2'b00, bcd[9:8]};
        blank     = BLANK_LZ && (bcd[9:8] == 2'd0);
      end
      default: begin
        digit_en  = 3'b001;
        cur_digit = bcd[3:0];
        blank     = 1'b0;
      end
    endcase
  end

  always_comb begin
    seg = 7'b0000000;
    if (!blank) begin
      case (cur_digit)
        4'd0: seg = 7'b1111110;
        4'd1: seg = 7'b0110000;
        4'd2: seg = 7'b1101101;
        4'd3: seg = 7'b1111001;
        4'd4: seg = 7'b0110011;
        4'd5: seg = 7'b1011011;
        4'd6: seg = 7'b1011111;
        4'd7: seg = 7'b1110000;
        4'd8: seg = 7'b1111111;
        4'd9: seg = 7'b1111011;
        default: seg = 7'b0000000;
      endcase
    end
  end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clk cycles each digit stays enabled (legal range 2..2^20).
REQ-002 SHALL have parameter BLANK_LZ, default 1, meaning leading-zero blanking enable (1 = blank, 0 = show all digits).
REQ-003 SHALL have port clk  input  1  single system clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 asserts).
REQ-005 SHALL have port bin  input  8  unsigned value to display (CPU output register).
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse when a new BCD result is committed.
REQ-008 SHALL have port bcd  output  10  committed result {hundreds[9:8], tens[7:4], ones[3:0]}.
REQ-009 SHALL have port seg  output  7  active-high segments, seg[6]=a ... seg[0]=g, for the enabled digit.
REQ-010 SHALL have port digit_en  output  3  one-hot active-high digit select: bit0 ones, bit1 tens, bit2 hundreds.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, SHIFT, COMMIT.
REQ-012 In IDLE, SHALL start a conversion when bin != last_bin: load bin into the shift register, clear the BCD accumulator, set last_bin<=bin, clear the iteration counter, go to SHIFT.
REQ-013 In SHIFT, each cycle SHALL add 3 to every accumulator nibble >=5, then shift {accumulator, shift register} left by one; after the 8th iteration go to COMMIT.
REQ-014 In COMMIT, SHALL load bcd with the accumulator, pulse done for exactly one cycle, return to IDLE.
REQ-015 Latency: capture edge E0; iterations on E1..E8; bcd and done update on E9; busy high in cycles following E0 through E9's preceding cycle (9 cycles).
REQ-016 bin changes while busy SHALL be ignored for the running conversion; since last_bin holds the captured value, a differing bin SHALL start a new conversion on the first IDLE cycle after COMMIT.
REQ-017 bcd SHALL hold its value between commits; hundreds SHALL never exceed 2, each other digit SHALL never exceed 9.
REQ-018 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, digit index SHALL advance ones->tens->hundreds->ones.
REQ-019 digit_en SHALL be the one-hot decode of the digit index; exactly one bit high at all times.
REQ-020 seg SHALL decode the selected digit of bcd: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-021 With BLANK_LZ=1: hundreds SHALL show seg=0000000 when hundreds=0; tens SHALL show 0000000 when hundreds=0 and tens=0; ones SHALL never blank.
REQ-022 Display SHALL use only committed bcd, never in-progress accumulator values.

Reset
REQ-023 reset=0 SHALL immediately force: FSM IDLE, busy=0, done=0, bcd=0, last_bin=0, iteration counter=0, refresh counter=0, digit index=ones.
REQ-024 Resulting outputs during reset: digit_en=001, seg=1111110.
REQ-025 Reset asserted mid-conversion SHALL abort it with no commit; after release, if bin!=0 a fresh conversion SHALL start on the first active edge.
REQ-026 After release with bin=0, no conversion SHALL start and bcd SHALL remain 0.

Verification
REQ-027 bin 0->255 -> busy 9 cycles, done on E9, bcd=10'b10_0101_0101; scan shows 1101101, 1011011, 1011011.
REQ-028 BLANK_LZ=1, bin=7 -> bcd=0_0_7; hundreds and tens seg=0000000; ones seg=1110000.
REQ-029 BLANK_LZ=1, bin=100 -> tens seg=1111110 (not blanked); hundreds seg=0110000.
REQ-030 bin=42, then bin=99 at E3 -> first commit bcd=0_4_2, second conversion starts the cycle after, commits bcd=0_9_9; exactly two done pulses.
REQ-031 bin=200, reset=0 at E4 for 2 cycles -> no done, bcd=0; after release conversion restarts and commits bcd=2_0_0.
REQ-032 REFRESH_DIV=4 -> digit_en sequence 001,010,100,001 each held 4 cycles; never zero or multi-hot.
